timer_slot_scheduler: RTL
=========================

Name: timer_slot_scheduler

Overview:
- Shares one prescaled down-counter between NREQ requesters, in front of `user_proj_timer` in the openframe user area.
- Each requester asks for a one-shot delay.
- The scheduler grants requesters round-robin, loads the counter, counts down, then returns a done pulse to the owner.
- Lets several GPIO-facing channels share one timer datapath without each instantiating its own counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 16, delay counter width in ticks.
- PW, 8, prescaler width.
- IDW, $clog2(NREQ), width of requester index.

Ports:
- wb_clk_i  input  1  sole clock; all state changes on its rising edge.
- wb_rst_i  input  1  reset; synchronous, active-high.
- req_i  input  NREQ  per-requester request level; held high until ack_o.
- delay_i  input  NREQ*CW  per-requester delay in ticks; slice i = [i*CW +: CW].
- prescale_i  input  PW  tick period minus one, shared by all requesters.
- cancel_i  input  NREQ  per-requester abort of an active slot.
- ack_o  output  NREQ  one-cycle grant pulse, one-hot.
- done_o  output  NREQ  one-cycle expiry pulse, one-hot.
- busy_o  output  1  high while a slot is running.
- cur_id_o  output  IDW  index of the current/last granted requester.
- count_o  output  CW  live remaining tick count.

Behaviour:
- Reset (wb_rst_i high at an edge): state=IDLE, rr pointer=0, counter=0, prescaler=0. Outputs: ack_o=0, done_o=0, busy_o=0, cur_id_o=0, count_o=0.
- Reset mid-RUN aborts silently; no done_o is issued.
- States:
  - IDLE: busy_o=0. If any req_i bit is high, select winner g by round-robin starting at the pointer (lowest index at or after the pointer, wrapping). Next edge: ack_o[g]=1 for one cycle, cur_id_o=g, counter=delay_i[g], prescale latched from prescale_i, prescaler=0, pointer=(g+1) mod NREQ, state=RUN. delay_i and prescale_i are sampled only at this edge.
  - RUN: busy_o=1.
    - If cancel_i[cur_id_o] is high: next edge goes to IDLE, no done_o, counter cleared. Cancel has priority over expiry in the same cycle.
    - Else if counter==0: next edge gives done_o[cur_id_o]=1 for one cycle and state=IDLE.
    - Else if prescaler==latched prescale: prescaler=0, counter=counter-1.
    - Else prescaler=prescaler+1.
    - cancel_i bits for non-current ids are ignored.
- Latency:
  - Request high in IDLE cycle N gives ack at N+1.
  - done_o at N+2+D*(P+1) for delay D and prescale P.
  - D=0 gives done at N+2.
- Back-to-back: the cycle carrying done_o is already IDLE and arbitrates. The next ack follows one cycle later, so there is no dead cycle beyond that.
- Requesters must deassert req_i on the cycle after ack_o. A req_i still high then is treated as a new request.
- req_i dropped before ack: the request is withdrawn with no side effects.
- req_i changes during RUN are ignored until IDLE.
- Counter never underflows. Max delay (2^CW-1) with max prescale completes normally; no wrap.
- count_o = counter register; it holds its last value (0) after done and reads 0 after cancel.
- ack_o and done_o are never high in the same cycle.

Test Plan:
- Single slot: P=0, req_i=0001, delay[0]=3 in cycle 10 -> ack_o=0001 at 11, count_o 3,2,1,0 at 11..14, done_o=0001 at 15, busy_o high 11..14.
- Prescale: P=4, delay[2]=2, request at cycle 0 -> ack at 1, done_o=0100 at 12 (=0+2+2*5); count_o decrements at edges 6 and 11.
- Round-robin fairness: all four req held continuously, each delay 0, P=0 -> ack order 0,1,2,3,0 at cycles 1,3,5,7,9; done at 2,4,6,8.
- Zero delay / boundary: delay=0 -> done exactly 1 cycle after ack. delay=16'hFFFF, P=0 -> done 65536 cycles after ack with no wrap.
- Cancel: delay[1]=10, cancel_i[1] pulsed 3 cycles after ack -> no done_o, busy_o low next cycle, count_o=0. cancel_i[3] pulsed while 1 is running -> no effect.
- Reset mid-run: wb_rst_i high 5 cycles into a delay=20 slot -> all outputs 0 the next cycle, no done_o ever. The next request is arbitrated from pointer 0.

Source files
------------

// File: rtl/timer_slot_scheduler_if.sv
// ---------------------------------------------------------------------------
// timer_slot_scheduler_if
//   Bundles the requester-facing signals of the shared one-shot timer.
//   master : requester side (drives req/delay/prescale/cancel)
//   slave  : scheduler side (drives ack/done/busy/cur_id/count)
//   Signals:
//     req_i       per-requester request level, held until ack_o
//     delay_i     per-requester delay in ticks, slice i = [i*CW +: CW]
//     prescale_i  tick period minus one, shared
//     cancel_i    per-requester abort of the running slot
//     ack_o       one-cycle one-hot grant pulse
//     done_o      one-cycle one-hot expiry pulse
//     busy_o      high while a slot is running
//     cur_id_o    index of the current/last granted requester
//     count_o     live remaining tick count
// ---------------------------------------------------------------------------
interface timer_slot_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CW   = 16,
  parameter int PW   = 8,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*CW-1:0] delay_i;
  logic [PW-1:0]      prescale_i;
  logic [NREQ-1:0]    cancel_i;
  logic [NREQ-1:0]    ack_o;
  logic [NREQ-1:0]    done_o;
  logic               busy_o;
  logic [IDW-1:0]     cur_id_o;
  logic [CW-1:0]      count_o;

  modport master (
    output req_i, delay_i, prescale_i, cancel_i,
    input  ack_o, done_o, busy_o, cur_id_o, count_o
  );

  modport slave (
    input  req_i, delay_i, prescale_i, cancel_i,
    output ack_o, done_o, busy_o, cur_id_o, count_o
  );
endinterface

// File: rtl/timer_slot_scheduler.sv
// ---------------------------------------------------------------------------
// timer_slot_scheduler
//   Shares one prescaled down-counter between NREQ requesters. An idle
//   scheduler grants the next requester round-robin, loads its delay, counts
//   ticks of (prescale+1) clocks each, and pulses done_o to the owner when
//   the count reaches zero. The owner may cancel its slot at any time.
//   Ports:
//     wb_clk_i  sole clock, rising edge
//     wb_rst_i  synchronous active-high reset
//     bus       timer_slot_scheduler_if.slave (requests, grants, status)
// ---------------------------------------------------------------------------
module timer_slot_scheduler #(
  parameter int NREQ = 4,
  parameter int CW   = 16,
  parameter int PW   = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  timer_slot_scheduler_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   psc_q, psc_d;
  logic [PW-1:0]   psc_lat_q, psc_lat_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [CW-1:0]   delay_arr [NREQ];
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [IDW:0]    scan_idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      delay_arr[i] = bus.delay_i[i*CW +: CW];
    end
  end

  // Round-robin pick: scan offsets from the pointer downward so the smallest
  // offset (closest at-or-after the pointer) is the last, winning, assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan_idx >= (IDW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      end
      if (bus.req_i[scan_idx[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    psc_d     = psc_q;
    psc_lat_d = psc_lat_q;
    ack_d     = '0;
    done_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          ack_d     = NREQ'(1) << grant_id;
          id_d      = grant_id;
          cnt_d     = delay_arr[grant_id];
          psc_lat_d = bus.prescale_i;
          psc_d     = '0;
          ptr_d     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Cancel outranks expiry; the counter is cleared so count_o reads 0.
        if (bus.cancel_i[id_q]) begin
          cnt_d   = '0;
          psc_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          done_d  = NREQ'(1) << id_q;
          state_d = IDLE;
        end else if (psc_q == psc_lat_q) begin
          psc_d = '0;
          cnt_d = cnt_q - 1'b1;
        end else begin
          psc_d = psc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (wb_rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      psc_q     <= '0;
      psc_lat_q <= '0;
      ack_q     <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      psc_q     <= psc_d;
      psc_lat_q <= psc_lat_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
    end
  end

  assign bus.ack_o    = ack_q;
  assign bus.done_o   = done_q;
  assign bus.busy_o   = (state_q == RUN);
  assign bus.cur_id_o = id_q;
  assign bus.count_o  = cnt_q;

endmodule
